// File: rtl/cpu_pkg.sv
// Shared CPU constants: jump opcodes and the default reset fetch address.
package cpu_pkg;

    localparam logic [5:0]  OP_J             = 6'b000010;
    localparam logic [5:0]  OP_JAL           = 6'b000011;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/jump_predecode.sv
// Combinational predecode of absolute j/jal targets so fetch can follow
// them without a bubble.
module jump_predecode
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        is_jump,
    output logic [31:0] target
);

    logic [31:0] seq_pc;

    assign seq_pc  = pc + 32'd4;
    assign is_jump = (instr[31:26] == OP_J) || (instr[31:26] == OP_JAL);
    // Region bits come from the delay-slot address, low bits from the word index.
    assign target  = (seq_pc & 32'hF000_0000) | {4'b0000, instr[25:0], 2'b00};

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register with
// valid/ready handshake, redirect handling and a sticky misaligned-redirect fault.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic        is_jump;
    logic        load;
    logic        redirect;

    jump_predecode u_predecode (
        .pc      (pc),
        .instr   (imem_instr),
        .is_jump (is_jump),
        .target  (jump_target)
    );

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign next_pc   = is_jump ? jump_target : pc_plus4;
    // A faulted stage is dead until reset: no loads, no redirects.
    assign load      = !fetch_fault && (!id_valid || id_ready);
    assign redirect  = redirect_valid && !fetch_fault;

    // PC, IF/ID register and fault capture; redirect beats load, reset beats all.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= 32'h0;
            id_pc       <= 32'h0;
            id_pc_plus4 <= 32'h0;
            fetch_fault <= 1'b0;
            fault_pc    <= 32'h0;
        end else if (redirect) begin
            id_valid <= 1'b0;
            if (redirect_pc[1:0] == 2'b00) begin
                pc <= redirect_pc;
            end else begin
                fetch_fault <= 1'b1;
                fault_pc    <= redirect_pc;
            end
        end else if (load) begin
            id_instr    <= imem_instr;
            id_pc       <= pc;
            id_pc_plus4 <= pc_plus4;
            id_valid    <= 1'b1;
            pc          <= next_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: per-cycle vector table, expected
// records queued when stimulus is driven and popped after the clock edge.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    logic [31:0] rom [256];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] ep4;
        logic [31:0] eaddr;
        logic        ef;
        logic [31:0] efpc;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory, word-indexed by low address bits.
    assign imem_instr = rom[imem_addr[9:2]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic vec_t mk(logic rst, logic rdy, logic rv, logic [31:0] rpc,
                                logic ev, logic [31:0] epc, logic [31:0] einstr,
                                logic [31:0] ep4, logic [31:0] eaddr,
                                logic ef, logic [31:0] efpc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.einstr = einstr; v.ep4 = ep4;
        v.eaddr = eaddr; v.ef = ef; v.efpc = efpc;
        return v;
    endfunction

    task automatic chk(string name, int step, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, required %h", name, step, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(int step, vec_t v);
        vec_t e;
        reset          = v.rst;
        id_ready       = v.rdy;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("id_valid",    step, {31'b0, id_valid},    {31'b0, e.ev});
        chk("id_pc",       step, id_pc,                e.epc);
        chk("id_instr",    step, id_instr,             e.einstr);
        chk("id_pc_plus4", step, id_pc_plus4,          e.ep4);
        chk("imem_addr",   step, imem_addr,            e.eaddr);
        chk("fetch_fault", step, {31'b0, fetch_fault}, {31'b0, e.ef});
        chk("fault_pc",    step, fault_pc,             e.efpc);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 | (i << 2);
        rom[2] = 32'h0800_0010;   // j 0x40 at address 0x8

        reset = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

        //          rst  rdy  rv   rpc            ev   id_pc          id_instr       id_pc_plus4    imem_addr      flt  fault_pc
        tbl.push_back(mk(1, 1, 0, 32'h0,         0, 32'h0,         32'h0,         32'h0,         32'h0,         0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h0,         0, 32'h0,         32'h0,         32'h0,         32'h0,         0, 32'h0));
        // straight-line fetch
        tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0,         32'hA000_0000, 32'h4,         32'h4,         0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h4,         32'hA000_0004, 32'h8,         32'h8,         0, 32'h0));
        // three-cycle stall holds everything
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h4,         32'hA000_0004, 32'h8,         32'h8,         0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h4,         32'hA000_0004, 32'h8,         32'h8,         0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h4,         32'hA000_0004, 32'h8,         32'h8,         0, 32'h0));
        // resume: jump at 0x8 goes straight to 0x40
        tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h8,         32'h0800_0010, 32'hC,         32'h40,        0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h40,        32'hA000_0040, 32'h44,        32'h44,        0, 32'h0));
        // redirect while stalled
        tbl.push_back(mk(0, 0, 1, 32'h100,       0, 32'h40,        32'hA000_0040, 32'h44,        32'h100,       0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h100,       32'hA000_0100, 32'h104,       32'h104,       0, 32'h0));
        // wrap at top of address space
        tbl.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 0, 32'h100,       32'hA000_0100, 32'h104,       32'hFFFF_FFFC, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'hA000_03FC, 32'h0,         32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0,         32'hA000_0000, 32'h4,         32'h4,         0, 32'h0));
        // misaligned redirect faults; later redirects are ignored
        tbl.push_back(mk(0, 1, 1, 32'h102,       0, 32'h0,         32'hA000_0000, 32'h4,         32'h4,         1, 32'h102));
        tbl.push_back(mk(0, 1, 1, 32'h200,       0, 32'h0,         32'hA000_0000, 32'h4,         32'h4,         1, 32'h102));
        tbl.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         32'hA000_0000, 32'h4,         32'h4,         1, 32'h102));
        // reset clears the fault
        tbl.push_back(mk(1, 1, 0, 32'h0,         0, 32'h0,         32'h0,         32'h0,         32'h0,         0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0,         32'hA000_0000, 32'h4,         32'h4,         0, 32'h0));

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        // Hand sequence: redirect beats a ready handshake, then jump target follow-up.
        apply(100, mk(0, 1, 1, 32'h8,   0, 32'h0,  32'hA000_0000, 32'h4,  32'h8,  0, 32'h0));
        apply(101, mk(0, 1, 0, 32'h0,   1, 32'h8,  32'h0800_0010, 32'hC,  32'h40, 0, 32'h0));
        apply(102, mk(0, 0, 0, 32'h0,   1, 32'h8,  32'h0800_0010, 32'hC,  32'h40, 0, 32'h0));
        // Hand sequence: reset in the middle of a stall.
        apply(103, mk(1, 0, 0, 32'h0,   0, 32'h0,  32'h0,         32'h0,  32'h0,  0, 32'h0));
        apply(104, mk(0, 0, 0, 32'h0,   1, 32'h0,  32'hA000_0000, 32'h4,  32'h4,  0, 32'h0));
        // Hand sequence: fault then reset while a redirect is also asserted.
        apply(105, mk(0, 1, 1, 32'h3,   0, 32'h0,  32'hA000_0000, 32'h4,  32'h4,  1, 32'h3));
        apply(106, mk(1, 1, 1, 32'h80,  0, 32'h0,  32'h0,         32'h0,  32'h0,  0, 32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port imem_addr, output, 32, fetch address driven to the instruction memory.
REQ-005 SHALL have port imem_instr, input, 32, instruction word returned combinationally for imem_addr in the same cycle.
REQ-006 SHALL have port redirect_valid, input, 1, branch/exception redirect request from a later stage.
REQ-007 SHALL have port redirect_pc, input, 32, redirect target address.
REQ-008 SHALL have port id_valid, output, 1, IF/ID register holds a valid instruction.
REQ-009 SHALL have port id_ready, input, 1, decode accepts the IF/ID contents this cycle.
REQ-010 SHALL have port id_instr, output, 32, registered instruction word.
REQ-011 SHALL have port id_pc, output, 32, address of id_instr.
REQ-012 SHALL have port id_pc_plus4, output, 32, id_pc + 4 (mod 2^32).
REQ-013 SHALL have port fetch_fault, output, 1, sticky misaligned-redirect flag.
REQ-014 SHALL have port fault_pc, output, 32, captured misaligned redirect address.

Function
REQ-015 SHALL drive imem_addr = pc combinationally; pc is an internal 32-bit register.
REQ-016 SHALL define load = !fault && (!id_valid || id_ready) and redirect = redirect_valid && !fault.
REQ-017 SHALL, on redirect with redirect_pc[1:0]==0: pc <= redirect_pc, id_valid <= 0, regardless of load or id_ready.
REQ-018 SHALL, on redirect with redirect_pc[1:0]!=0: fetch_fault <= 1, fault_pc <= redirect_pc, id_valid <= 0, pc unchanged.
REQ-019 SHALL, when no redirect and load: id_instr <= imem_instr, id_pc <= pc, id_pc_plus4 <= pc+4, id_valid <= 1, pc <= next_pc.
REQ-020 SHALL compute next_pc = {pc_plus4[31:28], imem_instr[25:0], 2'b00} when imem_instr[31:26] is 6'b000010 (j) or 6'b000011 (jal), else pc+4.
REQ-021 SHALL hold pc and all id_* registers when no redirect and not load (stall).
REQ-022 SHALL wrap pc+4 modulo 2^32 (32'hFFFFFFFC -> 32'h00000000), no flag.
REQ-023 SHALL present the instruction at address A on id_instr exactly one cycle after imem_addr==A with load asserted.
REQ-024 SHALL, once fetch_fault==1, keep id_valid=0, pc frozen, and ignore redirect_valid until reset.
REQ-025 SHALL sustain one instruction per cycle while id_ready==1 and no redirect.

Reset
REQ-026 SHALL, on reset high at a clock edge, set pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, fetch_fault=0, fault_pc=0.
REQ-027 SHALL give reset priority over redirect, load and stall, including mid-stall or mid-fault.
REQ-028 SHALL show imem_addr=RESET_PC in the first cycle after reset deasserts and id_valid=1 one cycle later.

Structure
REQ-029 SHALL take opcode constants OP_J=6'b000010 and OP_JAL=6'b000011 and the default reset PC from shared package cpu_pkg.
REQ-030 SHALL implement the jump-target predecode (REQ-020) as combinational sub-module jump_predecode (inputs pc, instr; outputs is_jump, target).

Verification
REQ-031 SHALL cover straight-line fetch: ROM words at 0x0,0x4,0x8, id_ready=1 -> id_pc 0x0,0x4,0x8 on consecutive cycles, id_valid continuously 1.
REQ-032 SHALL cover stall: id_ready=0 for 3 cycles with id_pc=0x4 -> id_pc, id_instr, imem_addr=0x8 held; resume -> id_pc=0x8 next cycle.
REQ-033 SHALL cover jump predecode: instr 32'h08000010 at 0x8 -> id_pc 0x8 then 0x40, never 0xC.
REQ-034 SHALL cover redirect during stall: id_valid=1, id_ready=0, redirect_pc=0x100 -> id_valid=0 next cycle, then id_pc=0x100.
REQ-035 SHALL cover misaligned redirect: redirect_pc=0x102 -> fetch_fault=1, fault_pc=0x102, id_valid stays 0 until reset, then pc=RESET_PC.
REQ-036 SHALL cover wrap: redirect_pc=32'hFFFFFFFC, non-jump instr -> following imem_addr=0x0, id_pc_plus4=0x0.
